// File: rtl/round_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared game-state codes, 7-segment constants and the round
//             scoreboard FSM state type.
//  Revision : 1.0  initial release
// ============================================================================
package game_pkg;

    // Game-state FSM codes driven by the upstream controller
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_END  = 2'd2;

    // Active-low segment patterns, bit0=a .. bit6=g
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Round scoreboard FSM states
    typedef enum logic [1:0] {
        SB_IDLE       = 2'd0,
        SB_ROUND      = 2'd1,
        SB_TALLY      = 2'd2,
        SB_MATCH_OVER = 2'd3
    } sb_state_t;

endpackage
`default_nettype wire

// File: rtl/round_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : round_scoreboard_if
//  Purpose  : Bundles the game/timer inputs and the score/display outputs of
//             the round scoreboard. master = driver side, slave = scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
interface round_scoreboard_if;
    logic [1:0] i_state;
    logic [1:0] i_who_wins;
    logic [2:0] i_min_ten;
    logic [3:0] i_min_one;
    logic [2:0] i_sec_ten;
    logic [3:0] i_sec_one;
    logic       i_clear;
    logic [3:0] o_p1_score;
    logic [3:0] o_p2_score;
    logic       o_match_over;
    logic [1:0] o_match_winner;
    logic [6:0] o_hex0;
    logic [6:0] o_hex1;
    logic [6:0] o_hex2;
    logic [6:0] o_hex3;
    logic [6:0] o_hex4;
    logic [6:0] o_hex5;
    logic [6:0] o_hex6;
    logic [6:0] o_hex7;

    modport master (
        output i_state, i_who_wins, i_min_ten, i_min_one, i_sec_ten, i_sec_one, i_clear,
        input  o_p1_score, o_p2_score, o_match_over, o_match_winner,
        input  o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_hex6, o_hex7
    );

    modport slave (
        input  i_state, i_who_wins, i_min_ten, i_min_one, i_sec_ten, i_sec_one, i_clear,
        output o_p1_score, o_p2_score, o_match_over, o_match_winner,
        output o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_hex6, o_hex7
    );
endinterface
`default_nettype wire

// File: rtl/round_scoreboard_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decoder
//  Purpose  : Combinational BCD digit to active-low 7-segment pattern.
//             Values above 9 produce a blank digit.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decoder
    import game_pkg::*;
(
    input  wire logic [3:0] digit_i,
    output logic      [6:0] seg_o
);

    // Segment lookup, bit0=a .. bit6=g, 0 = lit
    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/round_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : round_scoreboard
//  Purpose  : Counts rounds won per player in a first-to-WIN_ROUNDS match,
//             latches the match winner and drives eight 7-segment digits
//             (P1 score, dash, P2 score, blank, MM:SS timer).
//  Options  : `SCOREBOARD_BLINK_EN - blink the winner's digit in MATCH_OVER.
//  Revision : 1.0  initial release
// ============================================================================
module round_scoreboard
    import game_pkg::*;
#(
    parameter int WIN_ROUNDS = 3,
    parameter int BLINK_HALF = 12_500_000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    round_scoreboard_if.slave bus
);

    localparam logic [3:0] c_win_score = 4'(WIN_ROUNDS);

    sb_state_t  state_q;
    logic [1:0] prev_state_q;
    logic [3:0] p1_score_q;
    logic [3:0] p2_score_q;
    logic       match_over_q;
    logic [1:0] match_winner_q;
    logic [6:0] hex_q [8];

    logic       w_end_edge;
    logic       w_win_reached;
    logic       w_enter_over;
    logic       w_blink_off;
    logic [3:0] w_digit [6];
    logic [6:0] w_seg   [6];

    // A round ends on the first cycle the game FSM shows ST_END
    assign w_end_edge    = (bus.i_state == ST_END) && (prev_state_q != ST_END);
    assign w_win_reached = (p1_score_q == c_win_score) || (p2_score_q == c_win_score);
    assign w_enter_over  = (state_q == SB_TALLY) && w_win_reached && !bus.i_clear;

    // Match FSM: scores bump when the round-end edge is taken, winner one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SB_IDLE;
            prev_state_q   <= ST_INIT;
            p1_score_q     <= 4'd0;
            p2_score_q     <= 4'd0;
            match_over_q   <= 1'b0;
            match_winner_q <= 2'b00;
        end else begin
            prev_state_q <= bus.i_state;
            if (bus.i_clear) begin
                state_q        <= SB_IDLE;
                p1_score_q     <= 4'd0;
                p2_score_q     <= 4'd0;
                match_over_q   <= 1'b0;
                match_winner_q <= 2'b00;
            end else begin
                case (state_q)
                    SB_IDLE: begin
                        if (bus.i_state == ST_PLAY) state_q <= SB_ROUND;
                    end
                    SB_ROUND: begin
                        if (w_end_edge) begin
                            state_q <= SB_TALLY;
                            // Draw (11) and no-result (00) leave scores alone
                            if (bus.i_who_wins == 2'b01 && p1_score_q < c_win_score)
                                p1_score_q <= p1_score_q + 4'd1;
                            else if (bus.i_who_wins == 2'b10 && p2_score_q < c_win_score)
                                p2_score_q <= p2_score_q + 4'd1;
                        end
                    end
                    SB_TALLY: begin
                        if (w_win_reached) begin
                            state_q        <= SB_MATCH_OVER;
                            match_over_q   <= 1'b1;
                            match_winner_q <= (p1_score_q == c_win_score) ? 2'b01 : 2'b10;
                        end else begin
                            state_q <= SB_IDLE;
                        end
                    end
                    SB_MATCH_OVER: begin
                        state_q <= SB_MATCH_OVER;
                    end
                    default: state_q <= SB_IDLE;
                endcase
            end
        end
    end

`ifdef SCOREBOARD_BLINK_EN
    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [CNT_W-1:0] blink_cnt_q;
    logic             blink_phase_q;

    // Half-period counter; restarts on entry to MATCH_OVER so the digit shows first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (bus.i_clear || w_enter_over) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == CNT_W'(BLINK_HALF - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 1'b1;
        end
    end

    assign w_blink_off = (state_q == SB_MATCH_OVER) && blink_phase_q;
`else
    assign w_blink_off = 1'b0;
`endif

    // Digit sources for the six numeric displays
    assign w_digit[0] = p1_score_q;
    assign w_digit[1] = p2_score_q;
    assign w_digit[2] = {1'b0, bus.i_min_ten};
    assign w_digit[3] = bus.i_min_one;
    assign w_digit[4] = {1'b0, bus.i_sec_ten};
    assign w_digit[5] = bus.i_sec_one;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_seg
            seg7_decoder u_dec (
                .digit_i (w_digit[gi]),
                .seg_o   (w_seg[gi])
            );
        end
    endgenerate

    // Registered display drive, winner digit masked during the blink-off phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) hex_q[i] <= SEG_BLANK;
        end else begin
            hex_q[7] <= (w_blink_off && match_winner_q == 2'b01) ? SEG_BLANK : w_seg[0];
            hex_q[6] <= SEG_DASH;
            hex_q[5] <= (w_blink_off && match_winner_q == 2'b10) ? SEG_BLANK : w_seg[1];
            hex_q[4] <= SEG_BLANK;
            hex_q[3] <= w_seg[2];
            hex_q[2] <= w_seg[3];
            hex_q[1] <= w_seg[4];
            hex_q[0] <= w_seg[5];
        end
    end

    assign bus.o_p1_score     = p1_score_q;
    assign bus.o_p2_score     = p2_score_q;
    assign bus.o_match_over   = match_over_q;
    assign bus.o_match_winner = match_winner_q;
    assign bus.o_hex0         = hex_q[0];
    assign bus.o_hex1         = hex_q[1];
    assign bus.o_hex2         = hex_q[2];
    assign bus.o_hex3         = hex_q[3];
    assign bus.o_hex4         = hex_q[4];
    assign bus.o_hex5         = hex_q[5];
    assign bus.o_hex6         = hex_q[6];
    assign bus.o_hex7         = hex_q[7];

endmodule
`default_nettype wire
